// File: rtl/vga_pkg.sv
// Shared VGA / VRAM definitions: colour and address widths, fetch FSM states,
// and the default 640x480 frame with its 320x128 bitmap geometry.
package vga_pkg;

    localparam int unsigned COLOR_W     = 8;
    localparam int unsigned VRAM_AW     = 13;

    localparam int unsigned H_VISIBLE   = 640;
    localparam int unsigned V_VISIBLE   = 480;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_TOTAL     = 525;

    localparam int unsigned IMG_W       = 320;
    localparam int unsigned IMG_H       = 128;
    localparam int unsigned IMG_V_SCALE = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFETCH,
        S_WAIT,
        S_RUN
    } fetch_state_t;

endpackage

// File: rtl/pixel_shifter.sv
// 8-bit MSB-first pixel shifter. Each bit is held for H_SCALE clocks, and
// 'reload' strobes on the last clock of a byte, when 'data' is taken in.
module pixel_shifter #(
    parameter int unsigned H_SCALE = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] data,
    output logic       bit_out,
    output logic       reload
);

    localparam int unsigned    HS_W    = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam logic [HS_W-1:0] HS_LAST = HS_W'(H_SCALE - 1);

    logic [7:0]      sreg;
    logic [7:0]      cur_sreg;
    logic [2:0]      pix;
    logic [2:0]      cur_pix;
    logic [HS_W-1:0] hs;
    logic [HS_W-1:0] cur_hs;
    logic            step;
    logic            last_hs;

    // A load is treated as a step taken from a freshly loaded register, so the
    // loading clock already shows bit 7 of the new byte.
    always_comb begin
        cur_sreg = load ? data : sreg;
        cur_pix  = load ? '0 : pix;
        cur_hs   = load ? '0 : hs;
        step     = load | run;
        last_hs  = (cur_hs == HS_LAST);
        bit_out  = cur_sreg[7];
        reload   = step && last_hs && (cur_pix == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sreg <= '0;
            pix  <= '0;
            hs   <= '0;
        end else if (step) begin
            if (last_hs) begin
                hs <= '0;
                if (cur_pix == 3'd7) begin
                    sreg <= data;
                    pix  <= '0;
                end else begin
                    sreg <= {cur_sreg[6:0], 1'b0};
                    pix  <= cur_pix + 3'd1;
                end
            end else begin
                hs   <= cur_hs + HS_W'(1);
                sreg <= cur_sreg;
                pix  <= cur_pix;
            end
        end
    end

endmodule

// File: rtl/vram_pixel_fetch.sv
// Fetches a 1 bpp bitmap from VRAM and scales it into the 640x480 frame.
// Optional VRAM_PIXEL_FETCH_SCROLL_EN adds scroll_row for vertical scrolling.
module vram_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE = IMG_W / 8,
    parameter int unsigned FB_LINES       = IMG_H,
    parameter int unsigned H_SCALE        = H_VISIBLE / IMG_W,
    parameter int unsigned V_SCALE        = IMG_V_SCALE
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               line_start,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic [COLOR_W-1:0] border_color,
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
    input  logic [6:0]         scroll_row,
`endif
    output logic [VRAM_AW-1:0] vram_rd_addr,
    input  logic [7:0]         vram_rd_data,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out
);

    localparam int unsigned       REP_W    = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(V_SCALE - 1);
    localparam logic [6:0]        ROW_LAST = 7'(FB_LINES - 1);
    localparam logic [VRAM_AW-1:0] BPL    = VRAM_AW'(BYTES_PER_LINE);

    fetch_state_t       state;
    logic [6:0]         row;
    logic [REP_W-1:0]   rep;
    logic               image_line;
    logic [5:0]         byte_idx;
    logic [VRAM_AW-1:0] base;
    logic [7:0]         next_byte;
    logic [1:0]         pend;

    logic               rise;
    logic               load;
    logic               run;
    logic               show;
    logic               pix_bit;
    logic               reload;
    logic               issue;
    logic [VRAM_AW-1:0] issue_addr;

`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
    logic [6:0]         row_start;
    logic [7:0]         shown;

    always_comb begin
        row_start = (32'(scroll_row) > FB_LINES - 1) ? ROW_LAST : scroll_row;
    end
`endif

    pixel_shifter #(
        .H_SCALE (H_SCALE)
    ) u_shifter (
        .clk     (clk),
        .nrst    (nrst),
        .load    (load),
        .run     (run),
        .data    (next_byte),
        .bit_out (pix_bit),
        .reload  (reload)
    );

    // In-line fetches step from the last issued address rather than 'base',
    // so a frame_start mid-line cannot redirect the line being drawn.
    always_comb begin
        rise       = de_in & ~de_out;
        load       = (state == S_WAIT) && rise;
        run        = (state == S_RUN) && de_in;
        show       = load || run;
        issue      = 1'b0;
        issue_addr = vram_rd_addr + VRAM_AW'(1);
        if (state == S_IDLE && line_start && image_line) begin
            issue      = 1'b1;
            issue_addr = base;
        end else if (load) begin
            issue = (BYTES_PER_LINE > 1);
        end else if (reload && (32'(byte_idx) + 32'd1 < BYTES_PER_LINE)) begin
            issue = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= S_IDLE;
            row          <= '0;
            rep          <= '0;
            image_line   <= 1'b0;
            byte_idx     <= '0;
            base         <= '0;
            next_byte    <= '0;
            pend         <= '0;
            vram_rd_addr <= '0;
            rgb_out      <= '0;
            de_out       <= 1'b0;
            hsync_out    <= 1'b1;
            vsync_out    <= 1'b1;
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
            shown        <= '0;
`endif
        end else begin
            de_out    <= de_in;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;

            if (!de_in)
                rgb_out <= '0;
            else if (show)
                rgb_out <= pix_bit ? fg_color : bg_color;
            else
                rgb_out <= border_color;

            // Read data is sampled two clocks after its address is registered.
            pend <= {pend[0], issue};
            if (pend[1])
                next_byte <= vram_rd_data;
            if (issue)
                vram_rd_addr <= issue_addr;

            case (state)
                S_IDLE:     if (line_start && image_line) state <= S_PREFETCH;
                S_PREFETCH: if (pend[1]) state <= S_WAIT;
                S_WAIT: begin
                    if (rise) begin
                        byte_idx <= 6'd1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue)
                        byte_idx <= byte_idx + 6'd1;
                    if (!de_in)
                        state <= S_IDLE;
                end
                default:    state <= S_IDLE;
            endcase

            if (frame_start) begin
                rep        <= '0;
                image_line <= 1'b1;
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
                row        <= row_start;
                base       <= VRAM_AW'(32'(row_start) * BYTES_PER_LINE);
                shown      <= '0;
`else
                row        <= '0;
                base       <= '0;
`endif
            end else if (state == S_RUN && !de_in && image_line) begin
                if (rep == REP_LAST) begin
                    rep <= '0;
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
                    shown <= shown + 8'd1;
                    if (shown == 8'(FB_LINES - 1))
                        image_line <= 1'b0;
                    if (row == ROW_LAST) begin
                        row  <= '0;
                        base <= '0;
                    end else begin
                        row  <= row + 7'd1;
                        base <= base + BPL;
                    end
`else
                    if (row == ROW_LAST) begin
                        image_line <= 1'b0;
                    end else begin
                        row  <= row + 7'd1;
                        base <= base + BPL;
                    end
`endif
                end else begin
                    rep <= rep + REP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// Directed bench for vram_pixel_fetch: drives line/frame strobes, models the
// 1-cycle-latency VRAM and checks pixels, syncs and the VRAM address trace.
module tb_vram_pixel_fetch;

    logic        clk = 1'b0;
    logic        nrst;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  fg_color;
    logic [7:0]  bg_color;
    logic [7:0]  border_color;
    logic [12:0] vram_rd_addr;
    logic [7:0]  vram_rd_data;
    logic [7:0]  rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
    logic [6:0]  scroll_row;
`endif

    logic [7:0]  mem [0:5119];
    int          passed = 0;
    int          total  = 0;
    int          failed = 0;
    logic [7:0]  rgb_log [0:639];
    logic [12:0] addr_q [$];
    logic [12:0] last_addr;
    logic        hs_obs;
    logic        de_obs;
    logic        de_pre;
    logic        vs_obs;
    logic [7:0]  blank_rgb;
    int          errs;
    int          amax;

    vram_pixel_fetch #(
        .BYTES_PER_LINE (40),
        .FB_LINES       (128),
        .H_SCALE        (2),
        .V_SCALE        (3)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .de_in        (de_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .fg_color     (fg_color),
        .bg_color     (bg_color),
        .border_color (border_color),
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
        .scroll_row   (scroll_row),
`endif
        .vram_rd_addr (vram_rd_addr),
        .vram_rd_data (vram_rd_data),
        .rgb_out      (rgb_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .de_out       (de_out)
    );

    always #20 clk = ~clk;

    always_ff @(posedge clk) vram_rd_data <= mem[vram_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic log_addr;
        if (vram_rd_addr !== last_addr) begin
            addr_q.push_back(vram_rd_addr);
            last_addr = vram_rd_addr;
        end
    endtask

    function automatic logic [7:0] exp_px(input int base, input int i);
        logic [7:0] b;
        b = mem[base + i / 16];
        return b[7 - (i / 2) % 8] ? fg_color : bg_color;
    endfunction

    // One display line: line_start, 5 blank clocks (hsync low on 2 of them),
    // de_len active clocks, then 3 blank clocks.
    task automatic run_line(input int de_len);
        addr_q.delete();
        last_addr  = vram_rd_addr;
        line_start = 1'b1;
        tick();
        log_addr();
        line_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            hsync_in = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            tick();
            log_addr();
            if (c == 1) hs_obs = hsync_out;
        end
        hsync_in = 1'b1;
        de_pre   = de_out;
        for (int i = 0; i < de_len; i++) begin
            de_in = 1'b1;
            tick();
            log_addr();
            rgb_log[i] = rgb_out;
            if (i == 0) de_obs = de_out;
        end
        de_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            log_addr();
            if (c == 0) blank_rgb = rgb_out;
        end
    endtask

    task automatic frame_pulse;
        vsync_in    = 1'b0;
        frame_start = 1'b1;
        tick();
        vs_obs      = vsync_out;
        frame_start = 1'b0;
        tick();
        vsync_in    = 1'b1;
        tick();
        tick();
    endtask

    task automatic image_errs(input int base, input int n, output int e);
        e = 0;
        for (int i = 0; i < n; i++)
            if (rgb_log[i] !== exp_px(base, i)) e++;
    endtask

    task automatic border_errs(input int n, output int e);
        e = 0;
        for (int i = 0; i < n; i++)
            if (rgb_log[i] !== border_color) e++;
    endtask

    initial begin
        nrst         = 1'b0;
        de_in        = 1'b1;
        hsync_in     = 1'b0;
        vsync_in     = 1'b1;
        line_start   = 1'b0;
        frame_start  = 1'b0;
        fg_color     = 8'hFF;
        bg_color     = 8'h00;
        border_color = 8'h1C;
`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
        scroll_row   = 7'd0;
`endif
        for (int a = 0; a < 5120; a++) mem[a] = 8'h00;
        mem[0]  = 8'h80;
        mem[40] = 8'hFF;

        // Reset held during an active line
        repeat (3) tick();
        check("rst_rgb", rgb_out, 8'h00);
        check("rst_de", de_out, 1'b0);
        check("rst_hsync", hsync_out, 1'b1);
        check("rst_vsync", vsync_out, 1'b1);
        check("rst_addr", vram_rd_addr, 13'd0);

        nrst     = 1'b1;
        hsync_in = 1'b1;
        tick();
        tick();
        check("post_rst_de", de_out, 1'b1);
        check("post_rst_border", rgb_out, 8'h1C);
        de_in = 1'b0;
        tick();
        tick();

        // No frame_start yet: border only, no VRAM reads
        run_line(640);
        check("noframe_reads", addr_q.size(), 0);
        border_errs(640, errs);
        check("noframe_border", errs, 0);

        frame_pulse();
        check("vsync_delay", vs_obs, 1'b0);

        // Line 0: byte 0 = 0x80
        run_line(640);
        check("l0_px0", rgb_log[0], 8'hFF);
        check("l0_px1", rgb_log[1], 8'hFF);
        check("l0_px2", rgb_log[2], 8'h00);
        image_errs(0, 640, errs);
        check("l0_all", errs, 0);
        check("de_before", de_pre, 1'b0);
        check("de_delay", de_obs, 1'b1);
        check("hsync_delay", hs_obs, 1'b0);
        check("blank_rgb", blank_rgb, 8'h00);

        run_line(640);
        image_errs(0, 640, errs);
        check("l1_all", errs, 0);
        run_line(640);
        image_errs(0, 640, errs);
        check("l2_all", errs, 0);

        // Line 3: row 1 (byte 40 = 0xFF), full address trace
        run_line(640);
        check("l3_px15", rgb_log[15], 8'hFF);
        check("l3_px16", rgb_log[16], 8'h00);
        image_errs(40, 640, errs);
        check("l3_all", errs, 0);
        check("l3_addr_count", addr_q.size(), 40);
        errs = 0;
        amax = 0;
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] !== 13'(40 + i)) errs++;
            if (int'(addr_q[i]) > amax) amax = int'(addr_q[i]);
        end
        check("l3_addr_seq", errs, 0);
        check("l3_addr_max", amax, 79);

        // Remaining image lines, shortened
        for (int ln = 4; ln < 384; ln++) begin
            run_line(16);
            if (ln == 5) begin
                image_errs(40, 16, errs);
                check("l5_first16", errs, 0);
            end
        end

        // Line 384: border, no reads
        run_line(640);
        border_errs(640, errs);
        check("l384_border", errs, 0);
        check("l384_reads", addr_q.size(), 0);

        // Reset in the middle of an image line
        frame_pulse();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (5) tick();
        de_in = 1'b1;
        repeat (20) tick();
        nrst = 1'b0;
        repeat (3) tick();
        check("midrst_rgb", rgb_out, 8'h00);
        check("midrst_de", de_out, 1'b0);
        check("midrst_addr", vram_rd_addr, 13'd0);
        nrst  = 1'b1;
        de_in = 1'b0;
        tick();
        tick();
        run_line(640);
        border_errs(640, errs);
        check("after_rst_border", errs, 0);
        check("after_rst_reads", addr_q.size(), 0);

        frame_pulse();
        run_line(32);
        check("restart_px0", rgb_log[0], 8'hFF);
        check("restart_px2", rgb_log[2], 8'h00);

`ifdef VRAM_PIXEL_FETCH_SCROLL_EN
        scroll_row = 7'd127;
        frame_pulse();
        run_line(16);
        check("scroll_l0_addr", addr_q[0], 13'd5080);
        run_line(16);
        run_line(16);
        run_line(16);
        check("scroll_l3_addr", addr_q[0], 13'd0);
        check("scroll_l3_px0", rgb_log[0], 8'hFF);
        for (int ln = 4; ln < 384; ln++) run_line(16);
        run_line(640);
        border_errs(640, errs);
        check("scroll_l384_border", errs, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
